// File: rtl/display_scheduler.sv
// View scheduler for the ALU display: rotates A/B/RES/FLAGS on a dwell timer or button press.
// Define SCHED_ALERT_EN to compile in flag-change detection and the timed ALERT view.
module display_scheduler #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int ALERT_CYCLES = 200_000_000,
  parameter int AUTO_ROTATE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] result,
  input  logic       zero,
  input  logic       carry,
  input  logic       overflow,
  input  logic       btn_next,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [1:0] view,
  output logic       alert
);

`ifdef SCHED_ALERT_EN
  localparam int CNT_MAX = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
`else
  localparam int CNT_MAX = DWELL_CYCLES;
`endif
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

`ifdef SCHED_ALERT_EN
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);
  typedef enum logic [2:0] {
    VIEW_A = 3'd0, VIEW_B = 3'd1, VIEW_RES = 3'd2, VIEW_FLAGS = 3'd3, ALERT = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    VIEW_A = 2'd0, VIEW_B = 2'd1, VIEW_RES = 2'd2, VIEW_FLAGS = 2'd3
  } state_t;
`endif

  function automatic state_t next_view(input state_t s);
    case (s)
      VIEW_A:   return VIEW_B;
      VIEW_B:   return VIEW_RES;
      VIEW_RES: return VIEW_FLAGS;
      default:  return VIEW_A;
    endcase
  endfunction

  function automatic logic [1:0] view_code(input state_t s);
`ifdef SCHED_ALERT_EN
    if (s == ALERT) return 2'd3;
`endif
    return s[1:0];
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [15:0]      digits_q, digits_d;
  logic [1:0]       view_q;
  logic [2:0]       flags;
  logic             dwell_exp;

  assign flags     = {overflow, carry, zero};
  assign dwell_exp = (AUTO_ROTATE != 0) && (dwell_q == DWELL_LAST);

`ifdef SCHED_ALERT_EN
  state_t           saved_q, saved_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic [2:0]       prev_flags_q;
  logic             flag_evt;
  logic             alert_q;

  assign flag_evt = (flags != prev_flags_q);
`endif

  // Next-state: a flag event outranks the button; button and dwell expiry share one step.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
`ifdef SCHED_ALERT_EN
    saved_d = saved_q;
    acnt_d  = acnt_q;
    if (state_q == ALERT) begin
      if (flag_evt)                 acnt_d  = '0;
      else if (btn_next)            state_d = next_view(saved_q);
      else if (acnt_q == ALERT_LAST) state_d = saved_q;
      else                          acnt_d  = acnt_q + 1'b1;
    end else if (flag_evt) begin
      saved_d = state_q;
      state_d = ALERT;
      acnt_d  = '0;
    end else
`endif
    if (btn_next || dwell_exp) state_d = next_view(state_q);
    else if (dwell_q != DWELL_LAST) dwell_d = dwell_q + 1'b1;

    if (state_d != state_q) dwell_d = '0;
`ifdef SCHED_ALERT_EN
    if (state_d != ALERT) acnt_d = '0;
`endif
  end

  always_comb begin
    digits_d = {4'hF, 3'b000, overflow, 3'b000, carry, 3'b000, zero};
    case (state_q)
      VIEW_A:   digits_d = {4'hA, 4'h0, a};
      VIEW_B:   digits_d = {4'hB, 4'h0, b};
      VIEW_RES: digits_d = {4'hC, 4'h0, result};
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= VIEW_A;
      dwell_q  <= '0;
      digits_q <= '0;
      view_q   <= '0;
`ifdef SCHED_ALERT_EN
      saved_q      <= VIEW_A;
      acnt_q       <= '0;
      prev_flags_q <= flags;
      alert_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      digits_q <= digits_d;
      view_q   <= view_code(state_q);
`ifdef SCHED_ALERT_EN
      saved_q      <= saved_d;
      acnt_q       <= acnt_d;
      prev_flags_q <= flags;
      alert_q      <= (state_q == ALERT);
`endif
    end
  end

  assign {d3, d2, d1, d0} = digits_q;
  assign view             = view_q;
`ifdef SCHED_ALERT_EN
  assign alert = alert_q;
`else
  assign alert = 1'b0;
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized scoreboard bench for display_scheduler against a view-level reference model.
module tb_display_scheduler;
  localparam int D = 4;
  localparam int A = 6;
`ifdef SCHED_ALERT_EN
  localparam bit ALERT_EN = 1'b1;
`else
  localparam bit ALERT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, res;
  logic       zero, carry, ov, btn;
  logic [3:0] d0, d1, d2, d3;
  logic [1:0] view;
  logic       alert;
  logic [3:0] n0, n1, n2, n3;
  logic [1:0] nview;
  logic       nalert;

  typedef struct packed {
    logic [3:0] d3, d2, d1, d0;
    logic [1:0] view;
    logic       alert;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   ntests = 0;
  int   nfail  = 0;
  int   ncyc   = 0;

  // reference model state
  int         m_view, m_saved, m_dwell, m_acnt;
  bit         m_alert;
  logic [2:0] m_prev;
  logic [2:0] cur_fl;

  display_scheduler #(.DWELL_CYCLES(D), .ALERT_CYCLES(A), .AUTO_ROTATE(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .result(res),
    .zero(zero), .carry(carry), .overflow(ov), .btn_next(btn),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .view(view), .alert(alert)
  );

  display_scheduler #(.DWELL_CYCLES(D), .ALERT_CYCLES(A), .AUTO_ROTATE(0)) dut_norot (
    .clk(clk), .rst(rst), .a(a), .b(b), .result(res),
    .zero(1'b0), .carry(1'b0), .overflow(1'b0), .btn_next(1'b0),
    .d0(n0), .d1(n1), .d2(n2), .d3(n3), .view(nview), .alert(nalert)
  );

  always #5 clk = ~clk;

  task automatic cyc(input bit r, input logic [7:0] ia, input logic [7:0] ib,
                     input logic [7:0] ires, input logic [2:0] fl, input bit ibtn);
    exp_t e;
    int   code;
    bit   evt;
    @(negedge clk);
    rst = r; a = ia; b = ib; res = ires; {ov, carry, zero} = fl; btn = ibtn;
    e = '0;
    if (!r) begin
      m_view = 0; m_saved = 0; m_dwell = 0; m_acnt = 0; m_alert = 1'b0; m_prev = fl;
    end else begin
      code = m_alert ? 3 : m_view;
      case (code)
        0: begin e.d3 = 4'hA; {e.d1, e.d0} = ia; end
        1: begin e.d3 = 4'hB; {e.d1, e.d0} = ib; end
        2: begin e.d3 = 4'hC; {e.d1, e.d0} = ires; end
        default: begin
          e.d3 = 4'hF; e.d2 = {3'b0, fl[2]}; e.d1 = {3'b0, fl[1]}; e.d0 = {3'b0, fl[0]};
        end
      endcase
      e.view  = 2'(code);
      e.alert = m_alert;
      evt     = ALERT_EN && (fl != m_prev);
      m_prev  = fl;
      if (!m_alert) begin
        if (evt) begin
          m_saved = m_view; m_alert = 1'b1; m_acnt = 0; m_dwell = 0;
        end else if (ibtn || m_dwell == D - 1) begin
          m_view = (m_view + 1) % 4; m_dwell = 0;
        end else m_dwell++;
      end else begin
        if (evt) m_acnt = 0;
        else if (ibtn) begin
          m_alert = 1'b0; m_view = (m_saved + 1) % 4; m_dwell = 0;
        end else if (m_acnt == A - 1) begin
          m_alert = 1'b0; m_view = m_saved; m_dwell = 0;
        end else m_acnt++;
      end
    end
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      ncyc++;
      ntests++;
      if ({d3, d2, d1, d0, view, alert} !== mon_e) begin
        nfail++;
        $display("FAIL outputs cyc=%0d: got d=%h%h%h%h view=%0d alert=%b, want d=%h%h%h%h view=%0d alert=%b",
                 ncyc, d3, d2, d1, d0, view, alert,
                 mon_e.d3, mon_e.d2, mon_e.d1, mon_e.d0, mon_e.view, mon_e.alert);
      end
      ntests++;
      if (nview !== 2'd0 || nalert !== 1'b0) begin
        nfail++;
        $display("FAIL norotate cyc=%0d: got view=%0d alert=%b, want view=0 alert=0",
                 ncyc, nview, nalert);
      end
    end
  end

  initial begin
    rst = 1'b0; a = '0; b = '0; res = '0; zero = 0; carry = 0; ov = 0; btn = 0;
    cur_fl = 3'b000;
    // power-on reset, then a=3C visible and full rotation
    repeat (2) cyc(0, 8'h3C, 8'h5A, 8'h96, 3'b000, 0);
    repeat (22) cyc(1, 8'h3C, 8'h5A, 8'h96, 3'b000, 0);
    // button coinciding with dwell expiry in VIEW_B
    cyc(0, 8'h11, 8'h22, 8'h33, 3'b000, 0);
    repeat (7) cyc(1, 8'h11, 8'h22, 8'h33, 3'b000, 0);
    cyc(1, 8'h11, 8'h22, 8'h33, 3'b000, 1);
    repeat (3) cyc(1, 8'h11, 8'h22, 8'h33, 3'b000, 0);
    // carry rises while in VIEW_RES
    cyc(0, 8'h01, 8'h02, 8'h03, 3'b000, 0);
    repeat (8) cyc(1, 8'h01, 8'h02, 8'h03, 3'b000, 0);
    repeat (10) cyc(1, 8'h01, 8'h02, 8'h03, 3'b010, 0);
    // alert from VIEW_B: restart by second toggle, then button exit
    cyc(0, 8'hA5, 8'hB6, 8'hC7, 3'b000, 0);
    repeat (5) cyc(1, 8'hA5, 8'hB6, 8'hC7, 3'b000, 0);
    repeat (4) cyc(1, 8'hA5, 8'hB6, 8'hC7, 3'b001, 0);
    repeat (4) cyc(1, 8'hA5, 8'hB6, 8'hC7, 3'b000, 0);
    cyc(1, 8'hA5, 8'hB6, 8'hC7, 3'b000, 1);
    repeat (4) cyc(1, 8'hA5, 8'hB6, 8'hC7, 3'b000, 0);
    // zero toggles while in VIEW_A, with flag event and button together
    cyc(0, 8'h7E, 8'h00, 8'hFF, 3'b000, 0);
    cyc(1, 8'h7E, 8'h00, 8'hFF, 3'b001, 0);
    cyc(1, 8'h7E, 8'h00, 8'hFF, 3'b000, 1);
    repeat (8) cyc(1, 8'h7E, 8'h00, 8'hFF, 3'b000, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_fl = cur_fl ^ 3'($urandom_range(1, 7));
      cyc(($urandom_range(0, 299) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
          cur_fl, ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      ntests++;
      nfail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
